// File: rtl/leaf_out_packetizer_pkg.sv
// Shared constants for the leaf interface packet format: default field widths,
// field offsets and width helpers used by both output and input sides.
package leaf_out_packetizer_pkg;

    localparam int PAYLOAD_BITS_DEF  = 32;
    localparam int NUM_LEAF_BITS_DEF = 5;
    localparam int NUM_PORT_BITS_DEF = 4;
    localparam int NUM_ADDR_BITS_DEF = 7;

    // Packet layout from LSB upward: payload, addr, port, leaf, valid.
    localparam int PAYLOAD_LSB = 0;
    localparam int ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS_DEF;
    localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS_DEF;
    localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS_DEF;
    localparam int VALID_BIT   = LEAF_LSB + NUM_LEAF_BITS_DEF;

    localparam int PACKET_BITS_DEF = VALID_BIT + 1;

    function automatic int packet_bits(int leaf_bits, int port_bits, int addr_bits, int payload_bits);
        return 1 + leaf_bits + port_bits + addr_bits + payload_bits;
    endfunction

    // Credits count 0..D inclusive, so one bit wider than the address.
    function automatic int credit_bits(int addr_bits);
        return addr_bits + 1;
    endfunction

    function automatic int idx_bits(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/leaf_out_packetizer_if.sv
// User-stream and BFT-output bundle of the leaf output packetizer.
interface leaf_out_packetizer_if
    import leaf_out_packetizer_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 4,
    parameter int PAYLOAD_BITS  = PAYLOAD_BITS_DEF,
    parameter int PACKET_BITS   = PACKET_BITS_DEF
);
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
    logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;

    modport master (
        output din_leaf_user2interface,
        output vld_user2interface,
        input  ack_interface2user,
        input  dout_leaf_interface2bft
    );

    modport slave (
        input  din_leaf_user2interface,
        input  vld_user2interface,
        output ack_interface2user,
        output dout_leaf_interface2bft
    );
endinterface

// File: rtl/leaf_out_packetizer_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arbiter
    import leaf_out_packetizer_pkg::*;
#(
    parameter int N = 4,
    localparam int PTR_BITS = idx_bits(N)
) (
    input  logic [N-1:0]        req,
    input  logic [PTR_BITS-1:0] ptr,
    output logic [N-1:0]        grant,
    output logic [PTR_BITS-1:0] grant_idx
);
    always_comb begin
        int   idx;
        logic found;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PTR_BITS'(idx);
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/leaf_out_packetizer.sv
// Merges NUM_OUT_PORTS credited user streams into one BFT packet channel,
// stamping each payload with destination leaf/port and a wrapping buffer address.
module leaf_out_packetizer
    import leaf_out_packetizer_pkg::*;
#(
    parameter int PACKET_BITS           = PACKET_BITS_DEF,
    parameter int PAYLOAD_BITS          = PAYLOAD_BITS_DEF,
    parameter int NUM_LEAF_BITS         = NUM_LEAF_BITS_DEF,
    parameter int NUM_PORT_BITS         = NUM_PORT_BITS_DEF,
    parameter int NUM_ADDR_BITS         = NUM_ADDR_BITS_DEF,
    parameter int NUM_OUT_PORTS         = 4,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    leaf_out_packetizer_if.slave                bus,
    input  logic [NUM_OUT_PORTS*NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_OUT_PORTS*NUM_PORT_BITS-1:0] dest_port,
    input  logic                                credit_vld,
    input  logic [NUM_PORT_BITS-1:0]            credit_port,
    input  logic                                resend
);
    localparam int          CREDIT_BITS = credit_bits(NUM_ADDR_BITS);
    localparam int          PTR_BITS    = idx_bits(NUM_OUT_PORTS);
    localparam int unsigned DEPTH       = 32'(1) << NUM_ADDR_BITS;

    logic [CREDIT_BITS-1:0]   credit     [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_nxt [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr       [NUM_OUT_PORTS];
    logic [PTR_BITS-1:0]      rr_ptr;
    logic [PACKET_BITS-1:0]   out_reg;
    logic [NUM_OUT_PORTS-1:0] req;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic [NUM_OUT_PORTS-1:0] upd;
    logic [PTR_BITS-1:0]      gidx;

    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            req[i] = bus.vld_user2interface[i] && (credit[i] != '0) && !resend && !reset;
            upd[i] = credit_vld && (int'(credit_port) == i);
        end
    end

    rr_arbiter #(.N(NUM_OUT_PORTS)) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign bus.ack_interface2user      = grant;
    assign bus.dout_leaf_interface2bft = resend ? '0 : out_reg;

    // Grant implies credit > 0, so the decrement never underflows.
    always_comb begin
        int unsigned sum;
        sum = 0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            sum = 32'(credit[i]);
            if (upd[i])   sum = sum + 32'(FREESPACE_UPDATE_SIZE);
            if (grant[i]) sum = sum - 1;
            credit_nxt[i] = (sum > DEPTH) ? CREDIT_BITS'(DEPTH) : CREDIT_BITS'(sum);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            out_reg <= '0;
            // NOTE: the small per-port counter arrays are flops, not RAM, so resetting them is legal and required.
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= CREDIT_BITS'(DEPTH);
                addr[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit[i] <= credit_nxt[i];
                if (grant[i]) addr[i] <= addr[i] + 1'b1;
            end
            if (|grant) begin
                rr_ptr  <= (int'(gidx) == NUM_OUT_PORTS - 1) ? '0 : gidx + 1'b1;
                out_reg <= {1'b1,
                            dest_leaf[gidx*NUM_LEAF_BITS +: NUM_LEAF_BITS],
                            dest_port[gidx*NUM_PORT_BITS +: NUM_PORT_BITS],
                            addr[gidx],
                            bus.din_leaf_user2interface[gidx*PAYLOAD_BITS +: PAYLOAD_BITS]};
            end else begin
                out_reg <= '0;
            end
        end
    end
endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Scoreboard bench for leaf_out_packetizer with four output ports.
module tb_leaf_out_packetizer;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*5-1:0] dest_leaf;
    logic [N*4-1:0] dest_port;
    logic           credit_vld;
    logic [3:0]     credit_port;
    logic           resend;

    int n_err = 0;
    int n_chk = 0;

    int m_credit [N];
    int m_addr   [N];
    int m_rr;
    logic [48:0] exp_q [$];
    int grant_cnt [N];
    int grant_seq [$];

    leaf_out_packetizer_if #(.NUM_OUT_PORTS(N), .PAYLOAD_BITS(32), .PACKET_BITS(49)) bus ();

    leaf_out_packetizer #(.NUM_OUT_PORTS(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .dest_leaf   (dest_leaf),
        .dest_port   (dest_port),
        .credit_vld  (credit_vld),
        .credit_port (credit_port),
        .resend      (resend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called just after a rising edge: settle, compare, advance model, cross next edge.
    task automatic tick(input bit keep_din = 1'b0);
        logic [N-1:0] eg;
        logic [48:0]  pend;
        logic [48:0]  nxt;
        int gi;
        int c;
        if (!keep_din)
            for (int i = 0; i < N; i++) bus.din_leaf_user2interface[i*32 +: 32] = $urandom;
        #3;
        eg = '0;
        gi = -1;
        if (!reset && !resend)
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (gi < 0 && bus.vld_user2interface[idx] && m_credit[idx] > 0) gi = idx;
            end
        if (gi >= 0) eg[gi] = 1'b1;
        check("ack", 64'(bus.ack_interface2user), 64'(eg));
        for (int i = 0; i < N; i++)
            if (bus.ack_interface2user[i]) begin
                grant_cnt[i]++;
                grant_seq.push_back(i);
            end
        if (exp_q.size() > 0) begin
            pend = exp_q.pop_front();
            check("dout", 64'(bus.dout_leaf_interface2bft), resend ? 64'(0) : 64'(pend));
        end
        nxt = '0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_credit[i] = 128;
                m_addr[i]   = 0;
            end
            m_rr = 0;
        end else begin
            if (gi >= 0)
                nxt = {1'b1, dest_leaf[gi*5 +: 5], dest_port[gi*4 +: 4], 7'(m_addr[gi]),
                       bus.din_leaf_user2interface[gi*32 +: 32]};
            for (int i = 0; i < N; i++) begin
                c = m_credit[i];
                if (credit_vld && int'(credit_port) == i) c = c + 64;
                if (gi == i) c = c - 1;
                m_credit[i] = (c > 128) ? 128 : c;
            end
            if (gi >= 0) begin
                m_addr[gi] = (m_addr[gi] + 1) % 128;
                m_rr       = (gi + 1) % N;
            end
        end
        exp_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.vld_user2interface = '0;
        credit_vld = 1'b0;
        resend = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [48:0] single_exp;
        dest_leaf   = {5'd7, 5'd3, 5'd9, 5'd1};
        dest_port   = {4'd2, 4'd1, 4'd5, 4'd0};
        credit_port = '0;
        bus.din_leaf_user2interface = '0;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_rr", 64'(dut.rr_ptr), 64'd0);
        check("rst_credit3", 64'(dut.credit[3]), 64'd128);

        // Single packet from port 2
        bus.vld_user2interface = 4'b0100;
        bus.din_leaf_user2interface[2*32 +: 32] = 32'hDEADBEEF;
        tick(1'b1);
        bus.vld_user2interface = '0;
        single_exp = {1'b1, 5'd3, 4'd1, 7'd0, 32'hDEADBEEF};
        check("single_pkt", 64'(bus.dout_leaf_interface2bft), 64'(single_exp));
        check("single_addr", 64'(dut.addr[2]), 64'd1);
        check("single_credit", 64'(dut.credit[2]), 64'd127);
        ticks(2);

        // Fairness: all ports valid for 16 cycles
        do_reset();
        for (int i = 0; i < N; i++) grant_cnt[i] = 0;
        grant_seq.delete();
        bus.vld_user2interface = 4'b1111;
        ticks(16);
        bus.vld_user2interface = '0;
        for (int i = 0; i < N; i++) check("fair_cnt", 64'(grant_cnt[i]), 64'd4);
        for (int k = 0; k < grant_seq.size(); k++) check("fair_order", 64'(grant_seq[k]), 64'(k % N));
        ticks(2);

        // Credit exhaustion on port 0, then restore
        do_reset();
        bus.vld_user2interface = 4'b0001;
        ticks(128);
        check("exhaust_ack", 64'(bus.ack_interface2user[0]), 64'd0);
        credit_vld  = 1'b1;
        credit_port = 4'd0;
        tick();
        credit_vld = 1'b0;
        check("restore_credit", 64'(dut.credit[0]), 64'd64);
        check("restore_ack", 64'(bus.ack_interface2user[0]), 64'd1);
        tick();
        check("resume_valid", 64'(bus.dout_leaf_interface2bft[48]), 64'd1);
        check("resume_addr", 64'(bus.dout_leaf_interface2bft[38:32]), 64'd0);
        bus.vld_user2interface = '0;
        ticks(2);

        // Saturation, simultaneous update+transfer, out-of-range index
        do_reset();
        bus.vld_user2interface = 4'b0001;
        ticks(28);
        bus.vld_user2interface = '0;
        check("credit_100", 64'(dut.credit[0]), 64'd100);
        credit_vld = 1'b1;
        tick();
        credit_vld = 1'b0;
        check("sat_128", 64'(dut.credit[0]), 64'd128);
        bus.vld_user2interface = 4'b0001;
        ticks(118);
        check("credit_10", 64'(dut.credit[0]), 64'd10);
        credit_vld = 1'b1;
        tick();
        credit_vld = 1'b0;
        bus.vld_user2interface = '0;
        check("upd_xfer_73", 64'(dut.credit[0]), 64'd73);
        credit_vld  = 1'b1;
        credit_port = 4'd5;
        tick();
        credit_vld = 1'b0;
        check("oob_ignored", 64'(dut.credit[0]), 64'd73);
        ticks(2);

        // resend mid-stream with a credit update inside the window
        do_reset();
        bus.vld_user2interface = 4'b0011;
        ticks(4);
        resend      = 1'b1;
        credit_vld  = 1'b1;
        credit_port = 4'd1;
        #1;
        check("resend_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("resend_ack", 64'(bus.ack_interface2user), 64'd0);
        tick();
        credit_vld = 1'b0;
        ticks(2);
        resend = 1'b0;
        ticks(6);
        bus.vld_user2interface = '0;
        check("resend_credit1", 64'(dut.credit[1]), 64'd125);
        ticks(2);

        // Reset while port 1 is mid-stream
        do_reset();
        bus.vld_user2interface = 4'b0010;
        ticks(50);
        check("mid_addr50", 64'(dut.addr[1]), 64'd50);
        check("mid_credit78", 64'(dut.credit[1]), 64'd78);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.vld_user2interface = '0;
        check("mid_rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("mid_rst_addr", 64'(dut.addr[1]), 64'd0);
        check("mid_rst_credit", 64'(dut.credit[1]), 64'd128);
        check("mid_rst_rr", 64'(dut.rr_ptr), 64'd0);
        bus.vld_user2interface = 4'b1010;
        ticks(3);
        bus.vld_user2interface = '0;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/leaf_out_packetizer.md
# leaf_out_packetizer

Parametrised output stage for a leaf: merges NUM_OUT_PORTS user-side valid/ack streams into the single BFT output channel. It is a multi-output generalisation of the one-output path in the current leaf shell. The block arbitrates round-robin among ready ports and holds a per-port credit count of free slots at the destination buffer. It stamps each 32-bit payload with destination leaf, port and a wrapping buffer address to form a 49-bit packet. It sits between the user kernel outputs and `dout_leaf_interface2bft`, in the 400 MHz interface domain.

## Interface
Parameters:
- PACKET_BITS, 49, packet width: valid(1) + leaf + port + addr + payload
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, destination buffer address width; buffer depth D = 2^NUM_ADDR_BITS
- NUM_OUT_PORTS, 4, number of user output streams (1..16)
- FREESPACE_UPDATE_SIZE, 64, credits returned per credit update

Ports (one clock; reset is synchronous, active-high):
- clk  in  1  interface clock, all logic rising-edge
- reset  in  1  synchronous active-high reset
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  payloads, port i at slice i
- vld_user2interface  in  NUM_OUT_PORTS  per-port payload valid
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept, combinational
- dest_leaf  in  NUM_OUT_PORTS*NUM_LEAF_BITS  per-port destination leaf, quasi-static
- dest_port  in  NUM_OUT_PORTS*NUM_PORT_BITS  per-port destination input port, quasi-static
- credit_vld  in  1  one credit update this cycle
- credit_port  in  NUM_PORT_BITS  output port index the update applies to
- resend  in  1  suppress all output while high
- dout_leaf_interface2bft  out  PACKET_BITS  packet; bit 48 = valid

## Operation
- Packet layout: [48] valid=1, [47:43] dest_leaf, [42:39] dest_port, [38:32] addr, [31:0] payload.
- Per port i, the block keeps:
  - credit_i: NUM_ADDR_BITS+1 bits, reset to D.
  - addr_i: NUM_ADDR_BITS bits, reset to 0.
- Port i is eligible when vld_i=1, credit_i>0 and resend=0.
- Round-robin grant: search starts at rr_ptr and wraps. At most one grant per cycle. After a grant to port i, rr_ptr = (i+1) mod NUM_OUT_PORTS. rr_ptr resets to 0 and holds when nothing is granted.
- ack_i = grant_i. A transfer happens when vld_i and ack_i are both high. On a transfer:
  - credit_i decrements by 1.
  - addr_i increments, wrapping from D-1 to 0.
  - The packet is registered using the dest_leaf/dest_port values at that edge.
- Credit update: if credit_vld and credit_port<NUM_OUT_PORTS, credit_port gains FREESPACE_UPDATE_SIZE, saturating at D. An index >= NUM_OUT_PORTS is ignored.
- Update and transfer on the same port in the same cycle: new credit = min(D, credit+FREESPACE_UPDATE_SIZE-1).
- resend=1:
  - All acks are 0.
  - Output is all-zero.
  - Credits, addresses and rr_ptr hold.
  - Credit updates still apply.
- Reset mid-operation: any in-flight registered packet is discarded. Credits return to D and addresses to 0. The user side must treat the reset as a flush.

## Timing
- Reset values: dout_leaf_interface2bft=0, ack_interface2user=0, rr_ptr=0, all addr_i=0, all credit_i=D.
- Latency: a payload accepted at edge n appears on dout at cycle n+1, valid bit high, for exactly one cycle. dout is 0 in any cycle following no transfer.
- Output mask: dout_leaf_interface2bft = resend ? 0 : out_reg. The mask is combinational, and out_reg is also cleared when resend is high.
- Throughput: one packet per cycle aggregate. With all ports valid and credited, each port gets 1 in NUM_OUT_PORTS cycles.
- Credit exhaustion: when credit_i=0, ack_i stays 0 until the cycle after the edge on which credit is restored.
- No backpressure from the BFT; flow control is credit-only.

## Structure
- Shared package: field offsets, PACKET_BITS derivation, and the credit-width constant (NUM_ADDR_BITS+1). The leaf_interface input side reuses these.
- One sub-module, `rr_arbiter`: a parametrised N-way round-robin arbiter with a request vector, a pointer and a one-hot grant. Credit counters, address counters and the output register stay in the top.

## Test plan
- Single port: with NUM_OUT_PORTS=4, port 2 sends payload 0xDEADBEEF to dest_leaf=3, dest_port=1. Next cycle dout = {1, 5'd3, 4'd1, 7'd0, 32'hDEADBEEF}. addr_2 becomes 1 and credit_2 becomes 127.
- Fairness: all 4 ports valid continuously for 16 cycles gives grants in order 0,1,2,3 repeated, 4 packets per port.
- Credit exhaustion and return:
  - Port 0 sends 128 packets; addresses go 0..127. The 129th is not acked.
  - credit_vld with port 0 restores credit to 64 and transmission resumes at addr 0.
- Saturation and simultaneity:
  - An update at credit 100 yields 128, not 164.
  - An update together with a transfer at credit 10 yields 73.
- resend: 3 cycles of resend mid-stream force dout=0 and acks=0. Afterwards the stream resumes with the next address and nothing is skipped. A credit update during resend is applied.
- Reset while port 1 is mid-stream at addr 50 / credit 78: next cycle dout=0, addr_1=0, credit_1=128, rr_ptr=0.
